cc_register_bank: RTL and testbench

//  Parametrised, fully synchronous successor to the CPU-facing register file.

---
 rtl/cc_register_bank.sv | 136 +++++++++++++
 tb/tb_cc_register_bank.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_register_bank.sv
// CPU-facing register bank: byte-lane writes, registered reads, read-only status regs.
// Define CC_REGS_SHADOW_EN to add shadow copies that are transferred to the active set on latch.
module cc_register_bank #(
  parameter int unsigned          ADDR_WIDTH  = 8,
  parameter int unsigned          DATA_WIDTH  = 16,
  parameter int unsigned          NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         rd,
  input  logic                         wr,
  input  logic [DATA_WIDTH/8-1:0]      be,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_oe,
  output logic                         rd_valid,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_values,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_values,
  output logic [NUM_REGS-1:0]          write_pulse
`ifdef CC_REGS_SHADOW_EN
  ,
  input  logic                         latch
`endif
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  wr_q;
  logic                  commit;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NUM_REGS-1:0]   hit;
  logic [NUM_REGS-1:0]   pulse_d;
  // Bus-visible copy: the shadow when shadowing is enabled, else the active value.
  logic [DATA_WIDTH-1:0] bank_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] bank_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] active [NUM_REGS];

  // Rising edge of the strobe only; wr_q resets high so a held strobe never commits.
  assign commit = en & wr & ~wr_q & (|be);
  assign rd_req = en & rd & ~wr;

  always_comb begin
    lane_mask = '0;
    for (int unsigned k = 0; k < BE_WIDTH; k++) begin
      lane_mask[k*8 +: 8] = {8{be[k]}};
    end
  end

  always_comb begin
    hit     = '0;
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      hit[i] = (addr == ADDR_WIDTH'(i)) && !RO_MASK[i];
      if (addr == ADDR_WIDTH'(i)) begin
        rd_word = RO_MASK[i] ? ro_values[i*DATA_WIDTH +: DATA_WIDTH] : bank_q[i];
      end
    end
  end

  assign pulse_d = commit ? hit : '0;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      bank_d[i] = bank_q[i];
      if (pulse_d[i]) begin
        bank_d[i] = (bank_q[i] & ~lane_mask) | (data_in & lane_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q        <= 1'b1;
      data_out    <= '0;
      data_oe     <= 1'b0;
      rd_valid    <= 1'b0;
      write_pulse <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= RESET_VALUE;
      end
    end else begin
      wr_q        <= wr;
      data_oe     <= rd_req;
      rd_valid    <= rd_req;
      write_pulse <= pulse_d;
      if (rd_req) begin
        data_out <= rd_word;
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

`ifdef CC_REGS_SHADOW_EN
  logic [DATA_WIDTH-1:0] active_q [NUM_REGS];

  // Copy the post-write value so a commit coinciding with latch lands in the active set.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        active_q[i] <= RESET_VALUE;
      end else if (latch) begin
        active_q[i] <= bank_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      active[i] = active_q[i];
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      active[i] = bank_q[i];
    end
  end
`endif

  always_comb begin
    reg_values = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_values[i*DATA_WIDTH +: DATA_WIDTH] =
          RO_MASK[i] ? ro_values[i*DATA_WIDTH +: DATA_WIDTH] : active[i];
    end
  end

endmodule

// File: tb/tb_cc_register_bank.sv
// Scoreboard bench for cc_register_bank (16 x 16-bit, reg 15 read-only).
// Shadow checks run only when CC_REGS_SHADOW_EN is defined.
module tb_cc_register_bank;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned NR = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          rd;
  logic          wr;
  logic [1:0]    be;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic          rd_valid;
  logic [NR*DW-1:0] ro_values;
  logic [NR*DW-1:0] reg_values;
  logic [NR-1:0]    write_pulse;
`ifdef CC_REGS_SHADOW_EN
  logic          latch;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [$];
  int pulse_cnt [NR];

  always #5 clk = ~clk;

  cc_register_bank #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RESET_VALUE(16'h0000),
    .RO_MASK    (16'h8000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .rd         (rd),
    .wr         (wr),
    .be         (be),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .rd_valid   (rd_valid),
    .ro_values  (ro_values),
    .reg_values (reg_values),
    .write_pulse(write_pulse)
`ifdef CC_REGS_SHADOW_EN
    ,
    .latch      (latch)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rd_valid cycle pops one expected word.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < NR; i++) pulse_cnt[i] += int'(write_pulse[i]);
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_read", 32'(exp_q.size()), 32'd1);
        end else begin
          check_eq("rd_data", 32'(data_out), 32'(exp_q.pop_front()));
          check_eq("rd_oe", 32'(data_oe), 32'd1);
        end
      end
    end
  end

  function automatic int pulse_sum();
    int s = 0;
    for (int i = 0; i < NR; i++) s += pulse_cnt[i];
    return s;
  endfunction

  task automatic clear_pulses();
    for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    exp_q.push_back(exp);
    en   = 1'b1;
    rd   = 1'b1;
    addr = a;
    @(posedge clk);
    #1;
    en = 1'b0;
    rd = 1'b0;
    @(negedge clk);
    check_eq("rd_valid_latency", 32'(rd_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b,
                          input int hold);
    en      = 1'b1;
    wr      = 1'b1;
    addr    = a;
    data_in = d;
    be      = b;
    repeat (hold) @(posedge clk);
    #1;
    wr = 1'b0;
    en = 1'b0;
    be = 2'b00;
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    be        = 2'b00;
    addr      = '0;
    data_in   = '0;
    ro_values = '0;
    ro_values[255:240] = 16'h1234;
`ifdef CC_REGS_SHADOW_EN
    latch = 1'b0;
`endif
    clear_pulses();
    idle(3);

    // Reset state
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    check_eq("rst_data_oe", 32'(data_oe), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_write_pulse", 32'(write_pulse), 32'd0);
    check_eq("rst_reg0", 32'(reg_values[15:0]), 32'd0);
    check_eq("rst_reg15_ro", 32'(reg_values[255:240]), 32'h1234);
    reset = 1'b0;
    idle(1);

    // 1: read the whole map
    for (int i = 0; i < 15; i++) do_read(AW'(i), 16'h0000);
    do_read(8'd15, 16'h1234);

    // rd and wr together: write path only, bus not driven, data_out holds
    en = 1'b1; rd = 1'b1; wr = 1'b1; be = 2'b00; addr = 8'd0;
    @(posedge clk);
    #1;
    check_eq("rdwr_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rdwr_data_oe", 32'(data_oe), 32'd0);
    check_eq("hold_data_out", 32'(data_out), 32'h1234);
    en = 1'b0; rd = 1'b0; wr = 1'b0;
    idle(2);
    check_eq("be0_no_pulse", 32'(pulse_sum()), 32'd0);

    // 2: long strobe commits once
    clear_pulses();
    do_write(8'd0, 16'hdead, 2'b11, 4);
    check_eq("long_strobe_pulse0", 32'(pulse_cnt[0]), 32'd1);
    check_eq("long_strobe_pulse_total", 32'(pulse_sum()), 32'd1);
    do_read(8'd0, 16'hdead);
`ifndef CC_REGS_SHADOW_EN
    check_eq("reg_values0", 32'(reg_values[15:0]), 32'hdead);
`endif

    // 3: byte-lane merges
    do_write(8'd1, 16'hbeef, 2'b11, 1);
    do_write(8'd1, 16'h00ff, 2'b01, 1);
    do_write(8'd1, 16'hff00, 2'b10, 2);
    do_read(8'd1, 16'hffff);
`ifndef CC_REGS_SHADOW_EN
    check_eq("reg_values1", 32'(reg_values[31:16]), 32'hffff);
`endif

    // Read in the cycle right after a commit sees the new value
    en = 1'b1; wr = 1'b1; be = 2'b11; addr = 8'd5; data_in = 16'h5a5a;
    @(posedge clk);
    #1;
    wr = 1'b0; be = 2'b00; rd = 1'b1;
    exp_q.push_back(16'h5a5a);
    @(posedge clk);
    #1;
    rd = 1'b0; en = 1'b0;
    idle(2);

    // 4: writes to RO and unmapped addresses are dropped
    clear_pulses();
    do_write(8'd15, 16'hcafe, 2'b11, 1);
    do_write(8'd20, 16'hcafe, 2'b11, 1);
    check_eq("dropped_no_pulse", 32'(pulse_sum()), 32'd0);
    do_read(8'd15, 16'h1234);
    do_read(8'd20, 16'h0000);

    // 5: strobe held across reset release never commits
    clear_pulses();
    reset = 1'b1; en = 1'b1; wr = 1'b1; addr = 8'd3; data_in = 16'h1111; be = 2'b11;
    idle(2);
    reset = 1'b0;
    idle(3);
    wr = 1'b0; en = 1'b0; be = 2'b00;
    idle(2);
    check_eq("held_strobe_no_pulse", 32'(pulse_sum()), 32'd0);
    do_read(8'd3, 16'h0000);
    do_read(8'd0, 16'h0000);
    do_write(8'd3, 16'hface, 2'b11, 2);
    check_eq("rerise_pulse3", 32'(pulse_cnt[3]), 32'd1);
    check_eq("rerise_pulse_total", 32'(pulse_sum()), 32'd1);
    do_read(8'd3, 16'hface);

`ifdef CC_REGS_SHADOW_EN
    // 6: shadow vs active, latch alone and latch coinciding with commit
    do_write(8'd2, 16'hbead, 2'b11, 1);
    check_eq("shadow_active_unchanged", 32'(reg_values[47:32]), 32'd0);
    do_read(8'd2, 16'hbead);
    latch = 1'b1;
    @(posedge clk);
    #1;
    latch = 1'b0;
    check_eq("latch_active", 32'(reg_values[47:32]), 32'hbead);
    en = 1'b1; wr = 1'b1; be = 2'b11; addr = 8'd2; data_in = 16'h0f0f; latch = 1'b1;
    @(posedge clk);
    #1;
    latch = 1'b0; wr = 1'b0; en = 1'b0; be = 2'b00;
    check_eq("latch_commit_merged", 32'(reg_values[47:32]), 32'h0f0f);
    idle(2);
`endif

    idle(2);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
